// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// and mstatus bit positions.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  // Read/write machine CSRs
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Read-only CSRs
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // mstatus fields that exist in this implementation
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with an increment enable and independent
// low/high 32-bit write strobes (both strobes together = full 64-bit write).
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_next;

  // A write wins over the increment; a half-write freezes the other half.
  always_comb begin
    count_next = count + 64'(inc);
    if (wr_lo || wr_hi) begin
      count_next = count;
      if (wr_lo) count_next[31:0]  = wdata[31:0];
      if (wr_hi) count_next[63:32] = wdata[63:32];
    end
  end

  // Counter register, wraps naturally at 2^64.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= count_next;
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSRRW/CSRRS/CSRRC access, WARL masking, trap entry,
// mret, and the cycle/instret counters. Reads are combinational and always
// return the pre-write value; all state updates land on the next rising edge.
module csr_unit
  import csr_pkg::*;
#(
  parameter int           N         = 64,
  parameter logic [N-1:0] HARTID    = '0,
  parameter logic [N-1:0] MISA      = {(N == 64) ? 2'b10 : 2'b01, {(N-11){1'b0}}, 9'h100},
  parameter logic [N-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   csr_op,
  input  logic [11:0]  csr_addr,
  input  logic [N-1:0] csr_wdata,
  input  logic         csr_src_zero,
  output logic [N-1:0] csr_rdata,
  output logic         csr_illegal,
  input  logic         instr_retire,
  input  logic         trap_valid,
  input  logic [N-1:0] trap_cause,
  input  logic [N-1:0] trap_pc,
  input  logic [N-1:0] trap_val,
  input  logic         mret,
  output logic [N-1:0] trap_vector,
  output logic [N-1:0] epc_out,
  output logic         mie_out
);

  csr_op_t      op;
  logic         mie, mpie;
  logic [N-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0]  mcycle, minstret;
  logic [N-1:0] mstatus_rd;
  logic         addr_known, addr_ro, write_req, we;
  logic [N-1:0] wval;
  logic [63:0]  cnt_wdata;
  logic         cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  assign op = csr_op_t'(csr_op);

  // mstatus view: only MIE/MPIE are stored, MPP is hardwired to M-mode.
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mie;
    mstatus_rd[MSTATUS_MPIE] = mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Read mux and address classification (known / read-only).
  always_comb begin
    csr_rdata  = '0;
    addr_known = 1'b1;
    addr_ro    = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MTVAL:     csr_rdata = mtval;
      CSR_MCYCLE:    csr_rdata = N'(mcycle);
      CSR_MINSTRET:  csr_rdata = N'(minstret);
      CSR_MCYCLEH:   if (N == 32) csr_rdata = N'(mcycle[63:32]);   else addr_known = 1'b0;
      CSR_MINSTRETH: if (N == 32) csr_rdata = N'(minstret[63:32]); else addr_known = 1'b0;
      CSR_MISA:      begin csr_rdata = MISA;   addr_ro = 1'b1; end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: addr_ro = 1'b1;
      CSR_MHARTID:   begin csr_rdata = HARTID; addr_ro = 1'b1; end
      CSR_CYCLE:     begin csr_rdata = N'(mcycle);   addr_ro = 1'b1; end
      CSR_INSTRET:   begin csr_rdata = N'(minstret); addr_ro = 1'b1; end
      CSR_CYCLEH: begin
        addr_ro = 1'b1;
        if (N == 32) csr_rdata = N'(mcycle[63:32]); else addr_known = 1'b0;
      end
      CSR_INSTRETH: begin
        addr_ro = 1'b1;
        if (N == 32) csr_rdata = N'(minstret[63:32]); else addr_known = 1'b0;
      end
      default:       addr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero source is a pure read; RW always writes.
  assign write_req   = (op == CSR_RW) || !csr_src_zero;
  assign csr_illegal = (op != CSR_NONE) && (!addr_known || (addr_ro && write_req));
  assign we          = (op != CSR_NONE) && write_req && !csr_illegal && !trap_valid;

  // New value from the old value and the operation.
  always_comb begin
    case (op)
      CSR_RS:  wval = csr_rdata | csr_wdata;
      CSR_RC:  wval = csr_rdata & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  // Counter write strobes; for N=64 the low address writes all 64 bits.
  assign cnt_wdata = (N == 64) ? 64'(wval) : {2{32'(wval)}};
  assign cyc_wr_lo = we && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = we && ((N == 64) ? (csr_addr == CSR_MCYCLE) : (csr_addr == CSR_MCYCLEH));
  assign ins_wr_lo = we && (csr_addr == CSR_MINSTRET);
  assign ins_wr_hi = we && ((N == 64) ? (csr_addr == CSR_MINSTRET) : (csr_addr == CSR_MINSTRETH));

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (1'b1),
    .wr_lo   (cyc_wr_lo),
    .wr_hi   (cyc_wr_hi),
    .wdata   (cnt_wdata),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (instr_retire),
    .wr_lo   (ins_wr_lo),
    .wr_hi   (ins_wr_hi),
    .wdata   (cnt_wdata),
    .count   (minstret)
  );

  // CSR state: trap entry beats mret, mret beats a software mstatus write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= RESET_VEC;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_valid) begin
      mepc   <= {trap_pc[N-1:2], 2'b00};
      mcause <= trap_cause;
      mtval  <= trap_val;
      mpie   <= mie;
      mie    <= 1'b0;
    end else begin
      if (we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie  <= wval[MSTATUS_MIE];
            mpie <= wval[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec    <= {wval[N-1:2], wval[1] ? 2'b00 : wval[1:0]};
          CSR_MSCRATCH: mscratch <= wval;
          CSR_MEPC:     mepc     <= {wval[N-1:2], 2'b00};
          CSR_MCAUSE:   mcause   <= wval;
          CSR_MTVAL:    mtval    <= wval;
          default: ;
        endcase
      end
      if (mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
    end
  end

  // Redirect target: vectored mode offsets interrupts by 4 * cause code.
  always_comb begin
    trap_vector = {mtvec[N-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && trap_cause[N-1])
      trap_vector = {mtvec[N-1:2], 2'b00} + {trap_cause[N-3:0], 2'b00};
  end

  assign epc_out = mepc;
  assign mie_out = mie;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit (N=64): CSR access, illegal detection, WARL fields,
// counters, trap entry/mret and asynchronous reset.
module tb_csr_unit;
  import csr_pkg::*;

  localparam int          N         = 64;
  localparam logic [63:0] HARTID    = 64'h3;
  localparam logic [63:0] RESET_VEC = 64'h8000_0040;
  localparam logic [63:0] MISA_EXP  = 64'h8000_0000_0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        csr_src_zero;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        instr_retire;
  logic        trap_valid;
  logic [63:0] trap_cause, trap_pc, trap_val;
  logic        mret;
  logic [63:0] trap_vector, epc_out;
  logic        mie_out;

  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  longint unsigned tb_cycles = 0;

  csr_unit #(.N(N), .HARTID(HARTID), .RESET_VEC(RESET_VEC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_src_zero (csr_src_zero),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .instr_retire (instr_retire),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .trap_val     (trap_val),
    .mret         (mret),
    .trap_vector  (trap_vector),
    .epc_out      (epc_out),
    .mie_out      (mie_out)
  );

  // Clock and reference cycle count (edges seen out of reset)
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cycles <= 0;
    else          tb_cycles <= tb_cycles + 1;
  end

  // Driver: apply one access at the falling edge, sample, let it commit.
  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr,
                            input logic [63:0] wd, input logic sz,
                            output logic [63:0] rd, output logic ill);
    @(negedge clk);
    csr_op = op; csr_addr = addr; csr_wdata = wd; csr_src_zero = sz;
    #1;
    rd  = csr_rdata;
    ill = csr_illegal;
    @(posedge clk);
    #1;
    csr_op = 2'b00; csr_wdata = '0; csr_src_zero = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] rd, exp;
    logic        ill;
    logic [11:0] addrs[4] = '{CSR_MSTATUS, CSR_MTVEC, CSR_MHARTID, CSR_MISA};
    exp_q.push_back(64'h1800);
    exp_q.push_back(RESET_VEC);
    exp_q.push_back(HARTID);
    exp_q.push_back(MISA_EXP);
    for (int i = 0; i < 4; i++) begin
      csr_access(CSR_RS, addrs[i], '0, 1'b1, rd, ill);
      exp = exp_q.pop_front();
      n_vec++;
      if (rd !== exp) begin
        n_err++; $display("FAIL reset_read[%h]: got %h expected %h", addrs[i], rd, exp);
      end
      n_vec++;
      if (ill !== 1'b0) begin
        n_err++; $display("FAIL reset_illegal[%h]: got %b expected 0", addrs[i], ill);
      end
    end
    n_vec++;
    if (mie_out !== 1'b0 || epc_out !== 64'h0) begin
      n_err++; $display("FAIL reset_outputs: mie %b epc %h expected 0 0", mie_out, epc_out);
    end
  endtask

  task automatic test_retire();
    logic [63:0] rd, exp;
    logic        ill;
    @(negedge clk);
    instr_retire = 1'b1;
    repeat (3) @(posedge clk);
    #1 instr_retire = 1'b0;
    exp_q.push_back(64'd3);
    exp_q.push_back(64'd3);
    csr_access(CSR_RS, CSR_MINSTRET, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL minstret: got %h expected %h", rd, exp); end
    csr_access(CSR_RC, CSR_INSTRET, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL instret: got %h expected %h", rd, exp); end
  endtask

  task automatic test_rw_rs_rc();
    logic [63:0] rd, exp;
    logic        ill;
    logic [1:0]  ops[4] = '{CSR_RW, CSR_RS, CSR_RC, CSR_RS};
    logic [63:0] wds[4] = '{64'hDEAD, 64'h00F0, 64'h000D, 64'h0};
    logic        szs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hDEAD);
    exp_q.push_back(64'hDEFD);
    exp_q.push_back(64'hDEF0);
    for (int i = 0; i < 4; i++) begin
      csr_access(ops[i], CSR_MSCRATCH, wds[i], szs[i], rd, ill);
      exp = exp_q.pop_front(); n_vec++;
      if (rd !== exp) begin n_err++; $display("FAIL mscratch_step%0d: got %h expected %h", i, rd, exp); end
    end
  endtask

  task automatic test_illegal();
    logic [63:0] rd, exp;
    logic        ill;
    logic [11:0] addrs[6] = '{CSR_CYCLE, 12'h7C0, CSR_CYCLE, CSR_MCYCLEH, CSR_MISA, CSR_MHARTID};
    logic [1:0]  ops[6]   = '{CSR_RW, CSR_RW, CSR_RS, CSR_RS, CSR_RW, CSR_RC};
    logic        szs[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        exps[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      csr_access(ops[i], addrs[i], 64'h1, szs[i], rd, ill);
      n_vec++;
      if (ill !== exps[i]) begin
        n_err++; $display("FAIL illegal_flag%0d[%h]: got %b expected %b", i, addrs[i], ill, exps[i]);
      end
    end
    // Pure read of the read-only cycle counter is legal and reflects edge count
    exp_q.push_back(64'(tb_cycles));
    csr_access(CSR_RS, CSR_CYCLE, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp || ill !== 1'b0) begin
      n_err++; $display("FAIL cycle_read: got %h ill %b expected %h ill 0", rd, ill, exp);
    end
    exp_q.push_back(MISA_EXP);
    csr_access(CSR_RS, CSR_MISA, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL misa_unchanged: got %h expected %h", rd, exp); end
  endtask

  task automatic test_warl();
    logic [63:0] rd, exp;
    logic        ill;
    logic [11:0] addrs[5] = '{CSR_MSTATUS, CSR_MEPC, CSR_MTVEC, CSR_MTVEC, CSR_MTVEC};
    logic [63:0] wds[5]   = '{'1, 64'h123, 64'h2003, 64'h2002, 64'h2001};
    exp_q.push_back(64'h1888);
    exp_q.push_back(64'h120);
    exp_q.push_back(64'h2000);
    exp_q.push_back(64'h2000);
    exp_q.push_back(64'h2001);
    for (int i = 0; i < 5; i++) begin
      csr_access(CSR_RW, addrs[i], wds[i], 1'b0, rd, ill);
      csr_access(CSR_RS, addrs[i], '0, 1'b1, rd, ill);
      exp = exp_q.pop_front(); n_vec++;
      if (rd !== exp) begin n_err++; $display("FAIL warl%0d[%h]: got %h expected %h", i, addrs[i], rd, exp); end
    end
    csr_access(CSR_RW, CSR_MSTATUS, '0, 1'b0, rd, ill);
  endtask

  task automatic test_counter_wrap();
    logic [63:0] rd, exp;
    logic        ill;
    logic [1:0]  ops[5] = '{CSR_RW, CSR_RS, CSR_RS, CSR_RW, CSR_RS};
    logic [63:0] wds[5] = '{'1, '0, '0, 64'd5, '0};
    logic        szs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    csr_access(CSR_RW, CSR_MCYCLE, '1, 1'b0, rd, ill);
    exp_q.push_back('1);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h1);
    exp_q.push_back(64'd5);
    exp_q.push_back(64'd6);
    for (int i = 1; i < 5; i++) begin
      csr_access(ops[i], CSR_MCYCLE, wds[i], szs[i], rd, ill);
      exp = exp_q.pop_front(); n_vec++;
      if (rd !== exp) begin n_err++; $display("FAIL mcycle_step%0d: got %h expected %h", i, rd, exp); end
    end
    csr_access(CSR_RS, CSR_MCYCLE, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL mcycle_after_write: got %h expected %h", rd, exp); end
  endtask

  task automatic test_trap();
    logic [63:0] rd, exp;
    logic        ill;
    logic [11:0] addrs[4] = '{CSR_MEPC, CSR_MSTATUS, CSR_MCAUSE, CSR_MTVAL};
    csr_access(CSR_RS, CSR_MSTATUS, 64'h8, 1'b0, rd, ill);
    csr_access(CSR_RW, CSR_MTVEC, 64'h1001, 1'b0, rd, ill);
    @(negedge clk);
    trap_cause = 64'h7;
    #1;
    n_vec++;
    if (trap_vector !== 64'h1000) begin
      n_err++; $display("FAIL trap_vector_exc: got %h expected 1000", trap_vector);
    end
    trap_valid = 1'b1; trap_cause = 64'h8000_0000_0000_0007;
    trap_pc = 64'h206; trap_val = 64'hBAD;
    #1;
    n_vec++;
    if (trap_vector !== 64'h101C) begin
      n_err++; $display("FAIL trap_vector_irq: got %h expected 101c", trap_vector);
    end
    @(posedge clk);
    #1 trap_valid = 1'b0;
    exp_q.push_back(64'h204);
    exp_q.push_back(64'h1880);
    exp_q.push_back(64'h8000_0000_0000_0007);
    exp_q.push_back(64'hBAD);
    for (int i = 0; i < 4; i++) begin
      csr_access(CSR_RS, addrs[i], '0, 1'b1, rd, ill);
      exp = exp_q.pop_front(); n_vec++;
      if (rd !== exp) begin n_err++; $display("FAIL trap_state[%h]: got %h expected %h", addrs[i], rd, exp); end
    end
    n_vec++;
    if (epc_out !== 64'h204 || mie_out !== 1'b0) begin
      n_err++; $display("FAIL trap_outputs: epc %h mie %b expected 204 0", epc_out, mie_out);
    end
  endtask

  task automatic test_mret_priority();
    logic [63:0] rd, exp;
    logic        ill;
    @(negedge clk);
    mret = 1'b1;
    @(posedge clk);
    #1 mret = 1'b0;
    exp_q.push_back(64'h1888);
    csr_access(CSR_RS, CSR_MSTATUS, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp || mie_out !== 1'b1) begin
      n_err++; $display("FAIL mret_mstatus: got %h mie %b expected %h mie 1", rd, mie_out, exp);
    end
    // trap, mret and a CSR write together: only the trap takes effect
    @(negedge clk);
    trap_valid = 1'b1; mret = 1'b1; trap_pc = 64'h303; trap_cause = 64'h2;
    csr_op = CSR_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 64'h1234; csr_src_zero = 1'b0;
    @(posedge clk);
    #1;
    trap_valid = 1'b0; mret = 1'b0; csr_op = CSR_NONE; csr_wdata = '0;
    exp_q.push_back(64'hDEF0);
    exp_q.push_back(64'h1880);
    exp_q.push_back(64'h300);
    csr_access(CSR_RS, CSR_MSCRATCH, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL prio_mscratch: got %h expected %h", rd, exp); end
    csr_access(CSR_RS, CSR_MSTATUS, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL prio_mstatus: got %h expected %h", rd, exp); end
    csr_access(CSR_RS, CSR_MEPC, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL prio_mepc: got %h expected %h", rd, exp); end
  endtask

  task automatic test_async_reset();
    logic [63:0] rd, exp;
    logic        ill;
    csr_access(CSR_RS, CSR_MSTATUS, 64'h8, 1'b0, rd, ill);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    csr_op = CSR_RS; csr_addr = CSR_MSTATUS; csr_src_zero = 1'b1;
    #1;
    n_vec++;
    if (csr_rdata !== 64'h1800 || mie_out !== 1'b0 || epc_out !== 64'h0) begin
      n_err++; $display("FAIL async_reset: mstatus %h mie %b epc %h expected 1800 0 0", csr_rdata, mie_out, epc_out);
    end
    csr_addr = CSR_MSCRATCH;
    #1;
    n_vec++;
    if (csr_rdata !== 64'h0) begin
      n_err++; $display("FAIL async_reset_mscratch: got %h expected 0", csr_rdata);
    end
    csr_op = CSR_NONE; csr_src_zero = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(RESET_VEC);
    csr_access(CSR_RS, CSR_MTVEC, '0, 1'b1, rd, ill);
    exp = exp_q.pop_front(); n_vec++;
    if (rd !== exp) begin n_err++; $display("FAIL async_reset_mtvec: got %h expected %h", rd, exp); end
  endtask

  initial begin
    reset_n = 1'b0;
    csr_op = CSR_NONE; csr_addr = '0; csr_wdata = '0; csr_src_zero = 1'b0;
    instr_retire = 1'b0; trap_valid = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    test_reset();
    test_retire();
    test_rw_rs_rc();
    test_illegal();
    test_warl();
    test_counter_wrap();
    test_trap();
    test_mret_priority();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
